// File: rtl/sa_4x4_pkg.sv
// Shared constants and sizing helpers for the 4x4 array output path.
package sa_4x4_pkg;
  localparam int COLS           = 4;
  localparam int DATA_WIDTH_DEF = 16;

  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/out_row_store.sv
// ROWS x COLS word register file: whole-row write port, (row, column) read mux.
module out_row_store
  import sa_4x4_pkg::*;
#(
  parameter int DW   = 32,
  parameter int ROWS = 4,
  parameter int PW   = 2
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [PW-1:0] i_wr_row,
  input  logic [DW-1:0] i_w0,
  input  logic [DW-1:0] i_w1,
  input  logic [DW-1:0] i_w2,
  input  logic [DW-1:0] i_w3,
  input  logic [PW-1:0] i_rd_row,
  input  logic [1:0]    i_rd_col,
  output logic [DW-1:0] o_rd_data
);

  // Storage is deliberately not reset; validity is tracked by the pointers.
  logic [DW-1:0] r_mem [ROWS][COLS];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wr_row][0] <= i_w0;
      r_mem[i_wr_row][1] <= i_w1;
      r_mem[i_wr_row][2] <= i_w2;
      r_mem[i_wr_row][3] <= i_w3;
    end
  end

  assign o_rd_data = r_mem[i_rd_row][i_rd_col];

endmodule

// File: rtl/out_buffer_4x4_2dw.sv
// Row-in / word-out show-ahead FIFO for 4x4 array results (2*DATA_WIDTH words).
// Optional sticky overflow/underflow flags: define OUT_BUF_ERR_FLAGS_EN.
module out_buffer_4x4_2dw
  import sa_4x4_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ROWS       = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [2*DATA_WIDTH-1:0]           in0,
  input  logic [2*DATA_WIDTH-1:0]           in1,
  input  logic [2*DATA_WIDTH-1:0]           in2,
  input  logic [2*DATA_WIDTH-1:0]           in3,
  input  logic                              write,
  input  logic                              read,
  output logic [2*DATA_WIDTH-1:0]           out,
  output logic                              valid,
  output logic                              full,
  output logic                              empty,
  output logic [cnt_width(ROWS*COLS)-1:0]   count,
  output logic                              overflow,
  output logic                              underflow
);

  localparam int W  = 2 * DATA_WIDTH;
  localparam int CW = cnt_width(ROWS * COLS);
  localparam int PW = ptr_width(ROWS);
  localparam int RW = cnt_width(ROWS);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_row;
  logic [1:0]    r_col;
  logic [CW-1:0] r_count;
  logic [RW-1:0] r_rows;

  logic          w_full;
  logic          w_empty;
  logic          w_wr_ok;
  logic          w_rd_ok;
  logic          w_row_done;
  logic [W-1:0]  w_rd_data;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(ROWS - 1)) ? '0 : p + 1'b1;
  endfunction

  // A partly drained head row still occupies its slot, hence a row counter.
  assign w_full     = (r_rows == RW'(ROWS));
  assign w_empty    = (r_count == '0);
  assign w_wr_ok    = write & ~w_full;
  assign w_rd_ok    = read & ~w_empty;
  assign w_row_done = w_rd_ok & (r_col == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_row <= '0;
      r_col    <= '0;
      r_count  <= '0;
      r_rows   <= '0;
    end else begin
      if (w_wr_ok)    r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_rd_ok)    r_col    <= r_col + 2'd1;
      if (w_row_done) r_rd_row <= next_ptr(r_rd_row);
      r_count <= r_count + (w_wr_ok ? CW'(4) : CW'(0)) - (w_rd_ok ? CW'(1) : CW'(0));
      r_rows  <= r_rows + RW'(w_wr_ok) - RW'(w_row_done);
    end
  end

  out_row_store #(
    .DW   (W),
    .ROWS (ROWS),
    .PW   (PW)
  ) u_store (
    .clk       (clk),
    .i_we      (w_wr_ok),
    .i_wr_row  (r_wr_ptr),
    .i_w0      (in0),
    .i_w1      (in1),
    .i_w2      (in2),
    .i_w3      (in3),
    .i_rd_row  (r_rd_row),
    .i_rd_col  (r_col),
    .o_rd_data (w_rd_data)
  );

  assign out   = w_empty ? '0 : w_rd_data;
  assign valid = ~w_empty;
  assign full  = w_full;
  assign empty = w_empty;
  assign count = r_count;

`ifdef OUT_BUF_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (write & w_full)  r_overflow  <= 1'b1;
      if (read & w_empty)  r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_out_buffer_4x4_2dw.sv
// Randomized + directed bench for out_buffer_4x4_2dw against a word-queue model.
module tb_out_buffer_4x4_2dw;
  localparam int ROWS = 4;
`ifdef OUT_BUF_ERR_FLAGS_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        write;
  logic        read;
  logic [31:0] in0, in1, in2, in3;
  logic [31:0] out;
  logic        valid, full, empty, overflow, underflow;
  logic [4:0]  count;

  out_buffer_4x4_2dw #(.DATA_WIDTH(16), .ROWS(ROWS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .write     (write),
    .read      (read),
    .out       (out),
    .valid     (valid),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  // Model: the buffer is just a queue of words; rows held = ceil(words/4).
  logic [31:0] mq[$];
  bit          m_ovf;
  bit          m_udf;
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic int m_rows();
    return (mq.size() + 3) / 4;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit w, input bit r, input logic [31:0] a, b, c, d);
    bit full_now;
    bit empty_now;
    full_now  = (m_rows() == ROWS);
    empty_now = (mq.size() == 0);
    if (w && full_now)  m_ovf = ERR;
    if (r && empty_now) m_udf = ERR;
    if (r && !empty_now) void'(mq.pop_front());
    if (w && !full_now) begin
      mq.push_back(a); mq.push_back(b); mq.push_back(c); mq.push_back(d);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] e_out;
    e_out = (mq.size() > 0) ? mq[0] : 32'h0;
    chk("out",       out,           e_out);
    chk("valid",     32'(valid),    32'(mq.size() != 0));
    chk("empty",     32'(empty),    32'(mq.size() == 0));
    chk("full",      32'(full),     32'(m_rows() == ROWS));
    chk("count",     32'(count),    32'(mq.size()));
    chk("overflow",  32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow),32'(m_udf));
  end

  // Inputs change 1 time unit after a rising edge, well away from both edges.
  task automatic step(input bit w, input bit r, input logic [31:0] a, b, c, d);
    write = w; read = r; in0 = a; in1 = b; in2 = c; in3 = d;
    @(posedge clk);
    model_update(w, r, a, b, c, d);
    #1;
    write = 1'b0; read = 1'b0;
  endtask

  task automatic wr_row(input logic [31:0] a, b, c, d);
    step(1'b1, 1'b0, a, b, c, d);
  endtask

  task automatic rd();
    step(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    write = 1'b0; read = 1'b0;
    rst = 1'b1;
    mq.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; write = 1'b0; read = 1'b0;
    in0 = '0; in1 = '0; in2 = '0; in3 = '0;
    do_reset();

    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_out",   out,        32'd0);

    // Two rows drain in row-major order; first word visible one cycle after write.
    wr_row(1, 2, 3, 4);
    chk("lat_valid", 32'(valid), 32'd1);
    chk("lat_out",   out,        32'd1);
    wr_row(5, 6, 7, 8);
    chk("two_rows_count", 32'(count), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_out", out, 32'(i));
      chk("drain_count", 32'(count), 32'(9 - i));
      rd();
    end
    chk("drained_count", 32'(count), 32'd0);
    chk("drained_empty", 32'(empty), 32'd1);

    // Fill, then a dropped fifth write.
    do_reset();
    for (int r = 0; r < 4; r++) wr_row(32'(4*r+1), 32'(4*r+2), 32'(4*r+3), 32'(4*r+4));
    chk("fill_full",  32'(full),  32'd1);
    chk("fill_count", 32'(count), 32'd16);
    wr_row(99, 98, 97, 96);
    chk("drop_count", 32'(count),    32'd16);
    chk("drop_ovf",   32'(overflow), 32'(ERR));
    chk("drop_head",  out,           32'd1);
    step(1'b1, 1'b1, 77, 77, 77, 77);
    chk("drop_wr_rd_count", 32'(count), 32'd15);

    // Read while empty.
    do_reset();
    rd();
    chk("udf_count", 32'(count),     32'd0);
    chk("udf_out",   out,            32'd0);
    chk("udf_flag",  32'(underflow), 32'(ERR));

    // Simultaneous write and read with three rows held.
    do_reset();
    for (int r = 0; r < 3; r++) wr_row(32'(4*r+1), 32'(4*r+2), 32'(4*r+3), 32'(4*r+4));
    chk("three_count", 32'(count), 32'd12);
    step(1'b1, 1'b1, 32'h21, 32'h22, 32'h23, 32'h24);
    chk("wr_rd_count", 32'(count), 32'd15);
    chk("wr_rd_head",  out,        32'd2);

    // Wraparound: free the head row of a full buffer and refill slot 0.
    do_reset();
    for (int r = 0; r < 4; r++) wr_row(32'(4*r+1), 32'(4*r+2), 32'(4*r+3), 32'(4*r+4));
    for (int i = 0; i < 4; i++) rd();
    chk("freed_full", 32'(full), 32'd0);
    wr_row(32'hA, 32'hB, 32'hC, 32'hD);
    chk("wrap_count", 32'(count), 32'd16);
    for (int i = 5; i <= 16; i++) begin
      chk("wrap_old", out, 32'(i));
      rd();
    end
    for (int i = 0; i < 4; i++) begin
      chk("wrap_new", out, 32'(10 + i));
      rd();
    end
    chk("wrap_empty", 32'(empty), 32'd1);

    // Reset mid-drain at column 2.
    do_reset();
    wr_row(32'h31, 32'h32, 32'h33, 32'h34);
    wr_row(32'h41, 32'h42, 32'h43, 32'h44);
    rd(); rd();
    chk("mid_out", out, 32'h33);
    do_reset();
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    wr_row(32'h51, 32'h52, 32'h53, 32'h54);
    for (int i = 0; i < 4; i++) begin
      chk("mid_new", out, 32'(32'h51 + i));
      rd();
    end

    // Random traffic, alternating fill-biased and drain-biased phases.
    do_reset();
    for (int c = 0; c < 1200; c++) begin
      bit w;
      bit r;
      bit fill_phase;
      fill_phase = ((c / 100) % 2) == 0;
      w = fill_phase ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      r = fill_phase ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      else step(w, r, $urandom, $urandom, $urandom, $urandom);
    end

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
